// File: rtl/rat_sprite_ctrl.sv
// Rat sprite RAM sequencer: pixel-aligned reads from the VGA counters plus a
// four-phase host write port that only uses RAM cycles the read path leaves idle.
module rat_sprite_ctrl #(
    parameter int                    SPRITE_W   = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 4,
    parameter int                    V_ACTIVE   = 480,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic                  video_on,
    input  logic [10:0]           rat_x,
    input  logic [10:0]           rat_y,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic                  rat_on,
    output logic [DATA_WIDTH-1:0] rat_rgb,
    output logic [1:0]            wr_state_dbg
);
    localparam int SW = $clog2(SPRITE_W);

    // Handshake: wr_req rises with wr_addr/wr_data stable; they are captured on
    // acceptance. wr_ack rises after the RAM write and stays high until wr_req
    // falls; wr_ack falls the cycle after. A new request needs wr_ack low first.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PEND = 2'd1,
        W_ACK  = 2'd2
    } wr_state_t;

    wr_state_t             state, state_nx;
    logic [10:0]           ox, oy;
    logic [10:0]           dx, dy;
    logic                  in_box;
    logic                  read_slot;
    logic                  hit_d;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_data;

    // Negative offsets wrap to large unsigned values and fail the compare.
    assign dx        = x - ox;
    assign dy        = y - oy;
    assign in_box    = (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_W));
    assign read_slot = in_box & video_on;
    assign ram_addr_r = {dy[SW-1:0], dx[SW-1:0]};

    // Origin only moves during vertical blank so a frame never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ox <= '0;
            oy <= '0;
        end else if (x == 11'd0 && y == 11'(V_ACTIVE)) begin
            ox <= rat_x;
            oy <= rat_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_d <= 1'b0;
        end else begin
            hit_d <= read_slot;
        end
    end

    assign rat_on  = hit_d && (ram_dout != KEY_COLOR);
    assign rat_rgb = rat_on ? ram_dout : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= W_IDLE;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            state <= state_nx;
            if (state == W_IDLE && wr_req) begin
                hold_addr <= wr_addr;
                hold_data <= wr_data;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ram_we   = 1'b0;
        wr_ack   = 1'b0;
        case (state)
            W_IDLE: begin
                if (wr_req) state_nx = W_PEND;
            end
            W_PEND: begin
                if (!read_slot) begin
                    ram_we   = 1'b1;
                    state_nx = W_ACK;
                end
            end
            W_ACK: begin
                wr_ack = 1'b1;
                if (!wr_req) state_nx = W_IDLE;
            end
            default: state_nx = W_IDLE;
        endcase
    end

    assign ram_addr_w   = hold_addr;
    assign ram_din      = hold_data;
    assign wr_state_dbg = state;

endmodule

// File: tb/tb_rat_sprite_ctrl.sv
// Bench for rat_sprite_ctrl: behavioural sprite RAM, pixel-level reference
// model of what the sprite should show, directed tables and random scans.
module tb_rat_sprite_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y, rat_x, rat_y;
    logic        video_on;
    logic [9:0]  ram_addr_r, ram_addr_w, wr_addr;
    logic [3:0]  ram_dout, ram_din, wr_data, rat_rgb;
    logic        ram_we, wr_req, wr_ack, rat_on;
    logic [1:0]  wr_state_dbg;

    int checks = 0;
    int errors = 0;

    logic [3:0] init_pat [1024];
    logic [3:0] mem [1024];
    logic [3:0] model_mem [1024];
    logic       fill;

    int m_ox, m_oy;
    int prev_valid, p_on, p_rgb;

    typedef struct {
        int px, py, pv;
        int addr;
        int hit;
        int chk_addr;
    } vec_t;
    vec_t tab [9];

    rat_sprite_ctrl dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .rat_x(rat_x), .rat_y(rat_y), .ram_addr_r(ram_addr_r), .ram_dout(ram_dout),
        .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rat_on(rat_on), .rat_rgb(rat_rgb), .wr_state_dbg(wr_state_dbg)
    );

    always #5 clk = ~clk;

    // 32x32x4 sprite RAM with a one-cycle registered read.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_pat[i];
        end else if (ram_we) begin
            mem[ram_addr_w] <= ram_din;
        end
        ram_dout <= mem[ram_addr_r];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One pixel per cycle: checks the previous pixel's sprite output, then
    // predicts what the new pixel should produce next cycle.
    task automatic pix(input int px, input int py, input int pv);
        int hit, col;
        @(negedge clk);
        x = 11'(px);
        y = 11'(py);
        video_on = (pv != 0);
        #1;
        if (prev_valid != 0) begin
            chk("rat_on", int'(rat_on), p_on);
            chk("rat_rgb", int'(rat_rgb), p_rgb);
        end
        hit = (pv != 0 && px >= m_ox && px < m_ox + 32 && py >= m_oy && py < m_oy + 32) ? 1 : 0;
        col = (hit != 0) ? int'(model_mem[(py - m_oy) * 32 + (px - m_ox)]) : 0;
        p_on  = (hit != 0 && col != 0) ? 1 : 0;
        p_rgb = (p_on != 0) ? col : 0;
        prev_valid = 1;
        if (ram_we) chk("we_in_read_slot", hit, 0);
        if (px == 0 && py == 480) begin
            m_ox = int'(rat_x);
            m_oy = int'(rat_y);
        end
    endtask

    task automatic rand_pix();
        int px, py;
        px = m_ox + int'($urandom_range(0, 40)) - 4;
        py = m_oy + int'($urandom_range(0, 40)) - 4;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        pix(px, py, ($urandom_range(0, 9) < 8) ? 1 : 0);
    endtask

    task automatic host_write(input logic [9:0] a, input logic [3:0] d);
        int writes, acked;
        writes = 0;
        acked  = 0;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        for (int k = 1; k <= 300 && acked == 0; k++) begin
            rand_pix();
            if (ram_we) begin
                writes++;
                chk("rnd_we_addr", int'(ram_addr_w), int'(a));
                chk("rnd_we_data", int'(ram_din), int'(d));
                model_mem[a] = d;
            end
            if (wr_ack) begin
                acked = 1;
                chk("rnd_ack_latency_ge2", (k >= 2) ? 1 : 0, 1);
                chk("rnd_writes_before_ack", writes, 1);
            end
            if (k == 1) begin
                wr_addr = 10'($urandom);
                wr_data = 4'($urandom);
            end
        end
        chk("rnd_ack_seen", acked, 1);
        wr_req = 1'b0;
        rand_pix();
        chk("rnd_ack_clear", int'(wr_ack), 0);
        chk("rnd_no_extra_we", int'(ram_we), 0);
    endtask

    initial begin
        int exp_on;
        logic [3:0] d_old;

        tab[0] = '{105, 53, 1, 101,  1, 1};
        tab[1] = '{106, 53, 1, 102,  1, 1};
        tab[2] = '{ 99, 53, 1,   0,  0, 0};
        tab[3] = '{132, 53, 1,   0,  0, 0};
        tab[4] = '{131, 81, 1, 1023, 1, 1};
        tab[5] = '{131, 82, 1,   0,  0, 0};
        tab[6] = '{100, 50, 0,   0,  0, 1};
        tab[7] = '{100, 50, 1,   0,  1, 1};
        tab[8] = '{100, 49, 1,   0,  0, 0};

        for (int i = 0; i < 1024; i++) init_pat[i] = 4'($urandom);
        init_pat[101] = 4'h7;
        init_pat[102] = 4'h0;
        for (int i = 0; i < 1024; i++) model_mem[i] = init_pat[i];

        // Reset state, origin (0,0): pixel (5,3) reads address 101.
        reset = 1'b1; fill = 1'b1;
        x = 11'd5; y = 11'd3; video_on = 1'b0;
        rat_x = '0; rat_y = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        m_ox = 0; m_oy = 0; prev_valid = 0; p_on = 0; p_rgb = 0;
        repeat (3) @(negedge clk);
        chk("rst_rat_on", int'(rat_on), 0);
        chk("rst_rat_rgb", int'(rat_rgb), 0);
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_addr_5_3", int'(ram_addr_r), 101);
        reset = 1'b0; fill = 1'b0;

        // Latch origin (100,50) and run the vector table.
        rat_x = 11'd100; rat_y = 11'd50;
        pix(0, 480, 0);
        for (int i = 0; i < 9; i++) begin
            pix(tab[i].px, tab[i].py, tab[i].pv);
            if (tab[i].chk_addr != 0) chk("tab_addr", int'(ram_addr_r), tab[i].addr);
            chk("tab_ram_we", int'(ram_we), 0);
            exp_on = (tab[i].hit != 0 && tab[i].pv != 0 && model_mem[tab[i].addr] != 4'h0) ? 1 : 0;
            pix(700, 500, 0);
            chk("tab_rat_on", int'(rat_on), exp_on);
        end
        pix(105, 53, 1);
        pix(700, 500, 0);
        chk("key7_rgb", int'(rat_rgb), 7);
        pix(106, 53, 1);
        pix(700, 500, 0);
        chk("key0_rat_on", int'(rat_on), 0);
        chk("key0_rgb", int'(rat_rgb), 0);

        // Mid-frame origin request has no effect until the next latch.
        pix(50, 60, 1);
        rat_x = 11'd200;
        pix(105, 53, 1);
        pix(205, 53, 1);
        chk("nolatch_old_hit", int'(rat_rgb), 7);
        pix(700, 500, 0);
        chk("nolatch_new_miss", int'(rat_on), 0);
        pix(0, 480, 0);
        pix(205, 53, 1);
        pix(105, 53, 1);
        chk("latched_new_hit", int'(rat_rgb), 7);
        pix(700, 500, 0);
        chk("latched_old_miss", int'(rat_on), 0);

        // Write outside the box: one-cycle pulse, ack held until req drops.
        pix(700, 10, 0);
        wr_addr = 10'd101; wr_data = 4'hF; wr_req = 1'b1;
        pix(700, 10, 0);
        chk("wa_we", int'(ram_we), 1);
        chk("wa_addr", int'(ram_addr_w), 101);
        chk("wa_data", int'(ram_din), 15);
        chk("wa_ack_low", int'(wr_ack), 0);
        model_mem[101] = 4'hF;
        wr_addr = 10'd7; wr_data = 4'h3;
        for (int i = 0; i < 3; i++) begin
            pix(700, 10, 0);
            chk("wa_ack_held", int'(wr_ack), 1);
            chk("wa_we_once", int'(ram_we), 0);
        end
        wr_req = 1'b0;
        #1;
        chk("wa_ack_until_edge", int'(wr_ack), 1);
        pix(700, 10, 0);
        chk("wa_ack_cleared", int'(wr_ack), 0);
        pix(205, 53, 1);
        pix(700, 10, 0);
        chk("wa_readback", int'(rat_rgb), 15);

        // Request raised inside the box stalls until x leaves it.
        pix(200, 55, 1);
        wr_addr = 10'd5; wr_data = 4'h9; wr_req = 1'b1;
        for (int px = 201; px <= 231; px++) begin
            pix(px, 55, 1);
            chk("wb_stalled", int'(ram_we), 0);
        end
        pix(232, 55, 1);
        chk("wb_we_at_exit", int'(ram_we), 1);
        chk("wb_addr", int'(ram_addr_w), 5);
        chk("wb_data", int'(ram_din), 9);
        model_mem[5] = 4'h9;
        pix(233, 55, 1);
        chk("wb_ack", int'(wr_ack), 1);
        wr_req = 1'b0;
        pix(234, 55, 1);
        chk("wb_ack_clear", int'(wr_ack), 0);
        for (int px = 198; px <= 234; px++) pix(px, 56, 1);

        // Origin near the right edge: no wrap onto the next line's start.
        rat_x = 11'd620; rat_y = 11'd50;
        pix(0, 480, 0);
        for (int px = 615; px <= 639; px++) pix(px, 60, 1);
        for (int px = 0; px <= 11; px++) pix(px, 61, 1);
        pix(700, 500, 0);

        // Random origins, scans and host writes against the model.
        for (int r = 0; r < 6; r++) begin
            rat_x = 11'($urandom_range(0, 600));
            rat_y = 11'($urandom_range(0, 440));
            pix(0, 480, 0);
            for (int i = 0; i < 60; i++) rand_pix();
            for (int w = 0; w < 3; w++) host_write(10'($urandom), 4'($urandom));
        end

        // Reset while a write is pending drops it.
        rat_x = 11'd200; rat_y = 11'd50;
        pix(0, 480, 0);
        d_old = model_mem[101];
        pix(210, 60, 1);
        wr_addr = 10'd101; wr_data = d_old ^ 4'h5; wr_req = 1'b1;
        pix(211, 60, 1);
        chk("rp_stalled", int'(ram_we), 0);
        #1 reset = 1'b1;
        #1;
        chk("rp_rat_on", int'(rat_on), 0);
        chk("rp_rat_rgb", int'(rat_rgb), 0);
        chk("rp_wr_ack", int'(wr_ack), 0);
        chk("rp_ram_we", int'(ram_we), 0);
        wr_req = 1'b0; x = 11'd5; y = 11'd3;
        #1;
        chk("rp_origin_addr", int'(ram_addr_r), 101);
        m_ox = 0; m_oy = 0; prev_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix(5, 3, 1);
            chk("rp_no_write", int'(ram_we), 0);
        end
        pix(700, 500, 0);
        chk("rp_mem_kept", int'(rat_rgb), (d_old != 4'h0) ? int'(d_old) : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
